// File: rtl/mvm_request_ctrl.sv
// Sequences vertex fetch (4 words) -> mat_vec_mult4D launch -> 4-word result stream, per vertex.
// Latency: 5 fetch + 1 launch + 1 arm + engine time + 1 cycles from FETCH entry to the first out_valid.
// Backpressure: EMIT holds out_data/out_last until out_ready; start is ignored while busy.
module mvm_request_ctrl #(
    parameter int ADDR_W = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] vcount,
    output logic              busy,
    output logic              cmd_done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              eng_start,
    output logic [31:0]       eng_v1,
    output logic [31:0]       eng_v2,
    output logic [31:0]       eng_v3,
    output logic [31:0]       eng_v4,
    input  logic              eng_done,
    input  logic [31:0]       eng_o1,
    input  logic [31:0]       eng_o2,
    input  logic [31:0]       eng_o3,
    input  logic [31:0]       eng_o4,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic              out_last
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LAUNCH,
        ARM,
        WAIT,
        EMIT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] vidx_q, vidx_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [2:0]        fcnt_q, fcnt_d;
    logic [1:0]        widx_q, widx_d;
    logic              done_q, done_d;
    logic [31:0]       vreg_q [4];
    logic [31:0]       res_q [4];
    logic              last_vtx;

    // Compare against count-1 so a full-range vertex count never overflows the index.
    assign last_vtx = (vidx_q == (cnt_q - ADDR_W'(1)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vidx_d  = vidx_q;
        ptr_d   = ptr_q;
        fcnt_d  = fcnt_q;
        widx_d  = widx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (vcount != '0) begin
                        state_d = FETCH;
                        cnt_d   = vcount;
                        ptr_d   = base_addr;
                        vidx_d  = '0;
                        fcnt_d  = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (fcnt_q == 3'd4) begin
                    state_d = LAUNCH;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_q + 3'd1;
                end
            end
            LAUNCH: state_d = ARM;
            ARM: begin
                if (!eng_done) state_d = WAIT;
            end
            WAIT: begin
                if (eng_done) begin
                    state_d = EMIT;
                    widx_d  = '0;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    widx_d = widx_q + 2'd1;
                    if (widx_q == 2'd3) begin
                        if (last_vtx) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = FETCH;
                            vidx_d  = vidx_q + ADDR_W'(1);
                            ptr_d   = ptr_q + ADDR_W'(4);
                            fcnt_d  = '0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vidx_q  <= '0;
            ptr_q   <= '0;
            fcnt_q  <= '0;
            widx_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vidx_q  <= vidx_d;
            ptr_q   <= ptr_d;
            fcnt_q  <= fcnt_d;
            widx_q  <= widx_d;
            done_q  <= done_d;
        end
    end

    // Read data for fetch step k lands one cycle later, i.e. while fcnt = k+1.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) begin
                vreg_q[i] <= '0;
                res_q[i]  <= '0;
            end
        end else begin
            if (state_q == FETCH && fcnt_q != 3'd0)
                vreg_q[2'(fcnt_q - 3'd1)] <= mem_rdata;
            if (state_q == WAIT && eng_done) begin
                res_q[0] <= eng_o1;
                res_q[1] <= eng_o2;
                res_q[2] <= eng_o3;
                res_q[3] <= eng_o4;
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign cmd_done  = done_q;
    assign mem_rd    = (state_q == FETCH) && !fcnt_q[2];
    assign mem_addr  = ptr_q + ADDR_W'(fcnt_q[1:0]);
    assign eng_start = (state_q == LAUNCH);
    assign eng_v1    = vreg_q[0];
    assign eng_v2    = vreg_q[1];
    assign eng_v3    = vreg_q[2];
    assign eng_v4    = vreg_q[3];
    assign out_valid = (state_q == EMIT);
    assign out_data  = res_q[widx_q];
    assign out_last  = out_valid && (widx_q == 2'd3) && last_vtx;

endmodule
